// File: rtl/alu_uart_interface.sv
// Sequencer between uart_rx, the ALU and uart_tx: gathers operand A, operand B and
// opcode bytes, lets the ALU settle for one cycle, then sends the result and a Zero-flag byte.
module alu_uart_interface #(
   parameter int bits = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      rx_data,
   input  logic            rx_done,
   output logic [bits-1:0] alu_A,
   output logic [bits-1:0] alu_B,
   output logic [3:0]      alu_select,
   input  logic [bits-1:0] alu_C,
   input  logic            alu_zero,
   output logic [7:0]      tx_data,
   output logic            tx_start,
   input  logic            tx_done,
   output logic            busy
);

   typedef enum logic [2:0] {
      GET_A,
      GET_B,
      GET_OP,
      EXEC,
      SEND_RES,
      WAIT_RES,
      SEND_FLG,
      WAIT_FLG
   } state_t;

   state_t          state_q, state_d;
   logic [bits-1:0] alu_a_q, alu_a_d;
   logic [bits-1:0] alu_b_q, alu_b_d;
   logic [3:0]      alu_select_q, alu_select_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_start_q, tx_start_d;
   logic            zero_q, zero_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= GET_A;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_select_q <= '0;
         tx_data_q    <= '0;
         tx_start_q   <= 1'b0;
         zero_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_select_q <= alu_select_d;
         tx_data_q    <= tx_data_d;
         tx_start_q   <= tx_start_d;
         zero_q       <= zero_d;
      end
   end

   // tx_data and tx_start are loaded on entry to SEND_RES/SEND_FLG so the byte
   // is already valid in the single cycle the start strobe is high.
   always_comb begin
      state_d      = state_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_select_d = alu_select_q;
      tx_data_d    = tx_data_q;
      tx_start_d   = 1'b0;
      zero_d       = zero_q;
      case (state_q)
         GET_A: begin
            if (rx_done) begin
               alu_a_d = rx_data[bits-1:0];
               state_d = GET_B;
            end
         end
         GET_B: begin
            if (rx_done) begin
               alu_b_d = rx_data[bits-1:0];
               state_d = GET_OP;
            end
         end
         GET_OP: begin
            if (rx_done) begin
               alu_select_d = rx_data[3:0];
               state_d      = EXEC;
            end
         end
         EXEC: begin
            tx_data_d  = 8'(alu_C);
            zero_d     = alu_zero;
            tx_start_d = 1'b1;
            state_d    = SEND_RES;
         end
         SEND_RES: begin
            state_d = WAIT_RES;
         end
         WAIT_RES: begin
            if (tx_done) begin
               tx_data_d  = {7'b0, zero_q};
               tx_start_d = 1'b1;
               state_d    = SEND_FLG;
            end
         end
         SEND_FLG: begin
            state_d = WAIT_FLG;
         end
         WAIT_FLG: begin
            if (tx_done) begin
               state_d = GET_A;
            end
         end
         default: begin
            state_d = GET_A;
         end
      endcase
   end

   assign alu_A      = alu_a_q;
   assign alu_B      = alu_b_q;
   assign alu_select = alu_select_q;
   assign tx_data    = tx_data_q;
   assign tx_start   = tx_start_q;
   assign busy       = !(state_q inside {GET_A, GET_B, GET_OP});

endmodule
